// File: rtl/bp_cache_ctrl_pkg.sv
// Shared constants, cache entry layout and FSM encoding for the branch-prediction cache controller.
package bp_cache_ctrl_pkg;

    localparam int unsigned IDX_W      = 11;
    localparam int unsigned PC_W       = 13;
    localparam int unsigned TAG_W      = PC_W - IDX_W;
    localparam int unsigned WBUF_DEPTH = 2;

    // Entry layout: {valid, tag, target}
    localparam int unsigned ENT_W   = 1 + TAG_W + PC_W;
    localparam int unsigned VLD_BIT = ENT_W - 1;
    localparam int unsigned TAG_HI  = ENT_W - 2;
    localparam int unsigned TAG_LO  = PC_W;
    localparam int unsigned TGT_HI  = PC_W - 1;
    localparam int unsigned TGT_LO  = 0;

    typedef logic [ENT_W-1:0] entry_t;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    function automatic logic ent_vld(input entry_t e);
        return e[VLD_BIT];
    endfunction

    function automatic logic [TAG_W-1:0] ent_tag(input entry_t e);
        return e[TAG_HI:TAG_LO];
    endfunction

    function automatic logic [PC_W-1:0] ent_tgt(input entry_t e);
        return e[TGT_HI:TGT_LO];
    endfunction

endpackage

// File: rtl/bp_cache_ctrl_if.sv
// Fetch, update and RAM signals of the branch-prediction cache controller.
// Statistics outputs exist only when BP_STATS_EN is defined.
interface bp_cache_ctrl_if;
    import bp_cache_ctrl_pkg::*;

    logic             f_req;
    logic [PC_W-1:0]  f_pc;
    logic             f_vld;
    logic             f_hit;
    logic [PC_W-1:0]  f_target;
    logic             f_stall;
    logic             u_wen;
    entry_t           u_data;
    logic [IDX_W-1:0] u_addr;
    logic             inv_all;
    logic             init_busy;
    logic [IDX_W-1:0] mem_addr;
    logic             mem_wen;
    entry_t           mem_wdata;
    entry_t           mem_rdata;
`ifdef BP_STATS_EN
    logic [31:0]      stat_lookups;
    logic [31:0]      stat_hits;
    logic [31:0]      stat_updates;
`endif

    modport slave (
        input  f_req, f_pc, u_wen, u_data, u_addr, inv_all, mem_rdata,
        output f_vld, f_hit, f_target, f_stall, init_busy, mem_addr, mem_wen, mem_wdata
`ifdef BP_STATS_EN
        , output stat_lookups, stat_hits, stat_updates
`endif
    );

    modport master (
        output f_req, f_pc, u_wen, u_data, u_addr, inv_all, mem_rdata,
        input  f_vld, f_hit, f_target, f_stall, init_busy, mem_addr, mem_wen, mem_wdata
`ifdef BP_STATS_EN
        , input stat_lookups, stat_hits, stat_updates
`endif
    );

endinterface

// File: rtl/bp_wbuf.sv
// Coalescing FIFO of pending cache updates with an index-match forwarding port.
// Slot 0 is always the oldest entry; live entries are compacted below r_cnt.
module bp_wbuf
    import bp_cache_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH = WBUF_DEPTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clr,
    input  logic             i_push,
    input  logic [IDX_W-1:0] i_push_idx,
    input  entry_t           i_push_data,
    input  logic             i_pop,
    input  logic [IDX_W-1:0] i_lk_idx,
    output logic             o_full,
    output logic             o_empty,
    output logic [IDX_W-1:0] o_head_idx,
    output entry_t           o_head_data,
    output logic             o_fwd_hit,
    output entry_t           o_fwd_data
);
    localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
    localparam int unsigned SLOT_W = $clog2(DEPTH);

    logic [IDX_W-1:0]  r_idx  [DEPTH];
    entry_t            r_data [DEPTH];
    logic [CNT_W-1:0]  r_cnt;

    logic [IDX_W-1:0]  w_idx  [DEPTH];
    entry_t            w_data [DEPTH];
    logic [CNT_W-1:0]  w_cnt;
    logic              w_hit;
    logic [SLOT_W-1:0] w_slot;

    // Pop first, then match the push against the survivors, so an update to
    // the index being drained this cycle takes a fresh slot instead of being lost.
    always_comb begin
        w_idx  = r_idx;
        w_data = r_data;
        w_cnt  = r_cnt;
        w_hit  = 1'b0;
        w_slot = '0;
        if (i_pop && r_cnt != '0) begin
            for (int unsigned i = 0; i < DEPTH - 1; i++) begin
                w_idx[i]  = r_idx[i+1];
                w_data[i] = r_data[i+1];
            end
            w_cnt = r_cnt - 1'b1;
        end
        if (i_push) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (w_cnt > CNT_W'(i) && w_idx[i] == i_push_idx) begin
                    w_hit  = 1'b1;
                    w_slot = SLOT_W'(i);
                end
            end
            if (w_hit) begin
                w_data[w_slot] = i_push_data;
            end else if (w_cnt < CNT_W'(DEPTH)) begin
                w_idx[w_cnt[SLOT_W-1:0]]  = i_push_idx;
                w_data[w_cnt[SLOT_W-1:0]] = i_push_data;
                w_cnt = w_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || i_clr) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt;
        end
        r_idx  <= w_idx;
        r_data <= w_data;
    end

    always_comb begin
        o_fwd_hit  = 1'b0;
        o_fwd_data = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (r_cnt > CNT_W'(i) && r_idx[i] == i_lk_idx) begin
                o_fwd_hit  = 1'b1;
                o_fwd_data = r_data[i];
            end
        end
    end

    assign o_full      = (r_cnt == CNT_W'(DEPTH));
    assign o_empty     = (r_cnt == '0);
    assign o_head_idx  = r_idx[0];
    assign o_head_data = r_data[0];

endmodule

// File: rtl/bp_cache_ctrl.sv
// Branch-prediction cache controller: RAM clearing, fetch/update arbitration, update forwarding.
// Define BP_STATS_EN to add saturating lookup/hit/update counters.
module bp_cache_ctrl
    import bp_cache_ctrl_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    bp_cache_ctrl_if.slave bus
);
    state_t           r_state;
    state_t           w_next;
    logic [IDX_W-1:0] r_cnt;

    logic             r_lk_vld;
    logic [TAG_W-1:0] r_lk_tag;
    logic             r_fwd_vld;
    entry_t           r_fwd_data;

    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    logic             w_accept;
    logic             w_fwd_hit;
    logic [IDX_W-1:0] w_head_idx;
    entry_t           w_head_data;
    entry_t           w_fwd_data;
    entry_t           w_ent;

    assign w_push = (r_state == ST_RUN) && !bus.inv_all && bus.u_wen && ent_vld(bus.u_data);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_INIT;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            if (bus.inv_all) begin
                r_cnt <= '0;
            end else if (r_state == ST_INIT) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_INIT: if (r_cnt == '1) w_next = ST_RUN;
            ST_RUN:  w_next = ST_RUN;
            default: w_next = ST_INIT;
        endcase
        if (bus.inv_all) w_next = ST_INIT;
    end

    // A full buffer always wins the port so an enqueue can never find it full.
    always_comb begin
        w_pop         = 1'b0;
        w_accept      = 1'b0;
        bus.f_stall   = 1'b1;
        bus.init_busy = 1'b1;
        bus.mem_wen   = 1'b0;
        bus.mem_addr  = bus.f_pc[IDX_W-1:0];
        bus.mem_wdata = '0;
        case (r_state)
            ST_INIT: begin
                bus.mem_wen  = rst_n;
                bus.mem_addr = r_cnt;
            end
            ST_RUN: begin
                bus.init_busy = 1'b0;
                if (w_full) begin
                    w_pop = 1'b1;
                end else if (bus.f_req && !bus.inv_all) begin
                    w_accept    = 1'b1;
                    bus.f_stall = 1'b0;
                end else if (!w_empty) begin
                    w_pop = 1'b1;
                end
                if (w_pop) begin
                    bus.mem_wen   = 1'b1;
                    bus.mem_addr  = w_head_idx;
                    bus.mem_wdata = w_head_data;
                end
            end
            default: ;
        endcase
    end

    bp_wbuf #(
        .DEPTH(WBUF_DEPTH)
    ) u_wbuf (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_clr       (bus.inv_all),
        .i_push      (w_push),
        .i_push_idx  (bus.u_addr),
        .i_push_data (bus.u_data),
        .i_pop       (w_pop),
        .i_lk_idx    (bus.f_pc[IDX_W-1:0]),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_head_idx  (w_head_idx),
        .o_head_data (w_head_data),
        .o_fwd_hit   (w_fwd_hit),
        .o_fwd_data  (w_fwd_data)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_lk_vld   <= 1'b0;
            r_lk_tag   <= '0;
            r_fwd_vld  <= 1'b0;
            r_fwd_data <= '0;
        end else begin
            r_lk_vld <= w_accept;
            if (w_accept) begin
                r_lk_tag   <= bus.f_pc[PC_W-1:IDX_W];
                r_fwd_vld  <= w_fwd_hit;
                r_fwd_data <= w_fwd_data;
            end
        end
    end

    assign w_ent        = r_fwd_vld ? r_fwd_data : bus.mem_rdata;
    assign bus.f_vld    = r_lk_vld;
    assign bus.f_hit    = r_lk_vld && ent_vld(w_ent) && (ent_tag(w_ent) == r_lk_tag);
    assign bus.f_target = r_lk_vld ? ent_tgt(w_ent) : '0;

`ifdef BP_STATS_EN
    logic [31:0] r_stat_lookups;
    logic [31:0] r_stat_hits;
    logic [31:0] r_stat_updates;

    always_ff @(posedge clk) begin
        if (!rst_n || bus.inv_all) begin
            r_stat_lookups <= '0;
            r_stat_hits    <= '0;
            r_stat_updates <= '0;
        end else begin
            if (bus.f_vld && r_stat_lookups != '1) r_stat_lookups <= r_stat_lookups + 1'b1;
            if (bus.f_hit && r_stat_hits != '1)    r_stat_hits    <= r_stat_hits + 1'b1;
            if (w_push && r_stat_updates != '1)    r_stat_updates <= r_stat_updates + 1'b1;
        end
    end

    assign bus.stat_lookups = r_stat_lookups;
    assign bus.stat_hits    = r_stat_hits;
    assign bus.stat_updates = r_stat_updates;
`endif

endmodule

// File: tb/tb_bp_cache_ctrl.sv
// Directed bench for bp_cache_ctrl: clearing, lookups, forwarding, coalescing, full buffer, invalidate and mid-INIT reset.
module tb_bp_cache_ctrl;
    import bp_cache_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bp_cache_ctrl_if bus ();

    bp_cache_ctrl u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    entry_t ram [2**IDX_W];
    always @(posedge clk) begin
        if (bus.mem_wen) ram[bus.mem_addr] <= bus.mem_wdata;
        bus.mem_rdata <= ram[bus.mem_addr];
    end

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic sweep(input string tag, input int unsigned n);
        int unsigned bad = 0;
        for (int unsigned i = 0; i < n; i++) begin
            #1;
            if (!(bus.mem_wen === 1'b1 && bus.mem_addr === IDX_W'(i) && bus.mem_wdata === '0 &&
                  bus.init_busy === 1'b1 && bus.f_stall === 1'b1)) bad++;
            step();
        end
        check(tag, bad, 0);
    endtask

    task automatic lookup_chk(input string tag, input logic [PC_W-1:0] pc,
                              input logic exp_hit, input logic [PC_W-1:0] exp_tgt);
        int unsigned waits = 0;
        bus.f_req = 1'b1;
        bus.f_pc  = pc;
        #1;
        while (bus.f_stall && waits < 20) begin
            step();
            #1;
            waits++;
        end
        check({tag, "_acc"}, 32'(bus.f_stall), 0);
        step();
        bus.f_req = 1'b0;
        #1;
        check({tag, "_vld"}, 32'(bus.f_vld), 1);
        check({tag, "_hit"}, 32'(bus.f_hit), 32'(exp_hit));
        check({tag, "_tgt"}, 32'(bus.f_target), 32'(exp_tgt));
    endtask

    initial begin
        bus.f_req   = 1'b0;
        bus.f_pc    = '0;
        bus.u_wen   = 1'b0;
        bus.u_data  = '0;
        bus.u_addr  = '0;
        bus.inv_all = 1'b0;

        repeat (3) @(posedge clk);
        #3;
        check("rst_init_busy", 32'(bus.init_busy), 1);
        check("rst_f_stall",   32'(bus.f_stall), 1);
        check("rst_mem_wen",   32'(bus.mem_wen), 0);
        check("rst_f_vld",     32'(bus.f_vld), 0);
        check("rst_f_hit",     32'(bus.f_hit), 0);
        check("rst_f_target",  32'(bus.f_target), 0);
        rst_n = 1'b1;

        sweep("init_sweep", 2048);
        #1;
        check("init_done_busy", 32'(bus.init_busy), 0);
        check("init_done_wen",  32'(bus.mem_wen), 0);

        lookup_chk("cold", 13'h0123, 1'b0, 13'h0000);

        bus.u_wen  = 1'b1;
        bus.u_addr = 11'h123;
        bus.u_data = 16'h8456;
        step();
        bus.u_wen = 1'b0;
        step();
        step();
        lookup_chk("upd_hit",  13'h0123, 1'b1, 13'h0456);
        lookup_chk("tag_miss", 13'h0923, 1'b0, 13'h0456);

        // Forwarding from buffer while the write is starved by back-to-back lookups
        bus.u_wen  = 1'b1;
        bus.u_addr = 11'h055;
        bus.u_data = 16'h8777;
        bus.f_req  = 1'b1;
        bus.f_pc   = 13'h0001;
        step();
        bus.u_wen = 1'b0;
        bus.f_pc  = 13'h0055;
        #1;
        check("fwd_acc",     32'(bus.f_stall), 0);
        check("fwd_starved", 32'(bus.mem_wen), 0);
        step();
        #1;
        check("fwd_vld", 32'(bus.f_vld), 1);
        check("fwd_hit", 32'(bus.f_hit), 1);
        check("fwd_tgt", 32'(bus.f_target), 32'h0777);
        bus.f_req = 1'b0;
        step();
        step();

        // Coalescing: two updates to one index occupy a single slot
        bus.f_req  = 1'b1;
        bus.f_pc   = 13'h0002;
        bus.u_wen  = 1'b1;
        bus.u_addr = 11'h010;
        bus.u_data = 16'h8100;
        step();
        bus.u_data = 16'h8200;
        bus.f_pc   = 13'h0003;
        step();
        bus.u_wen = 1'b0;
        #1;
        check("coal_one_slot", 32'(bus.f_stall), 0);
        check("coal_no_write", 32'(bus.mem_wen), 0);
        bus.f_req = 1'b0;
        step();
        step();
        lookup_chk("coal", 13'h0010, 1'b1, 13'h0200);

        // Buffer full under continuous lookups
        bus.f_req  = 1'b1;
        bus.f_pc   = 13'h0004;
        bus.u_wen  = 1'b1;
        bus.u_addr = 11'h201;
        bus.u_data = 16'h80A1;
        step();
        bus.u_addr = 11'h202;
        bus.u_data = 16'h80A2;
        step();
        bus.u_addr = 11'h203;
        bus.u_data = 16'h80A3;
        #1;
        check("full_stall", 32'(bus.f_stall), 1);
        check("full_wen",   32'(bus.mem_wen), 1);
        check("full_addr",  32'(bus.mem_addr), 32'h201);
        check("full_wdata", 32'(bus.mem_wdata), 32'h80A1);
        step();
        bus.u_wen = 1'b0;
        #1;
        check("full_stall2", 32'(bus.f_stall), 1);
        check("full_addr2",  32'(bus.mem_addr), 32'h202);
        step();
        #1;
        check("full_drained", 32'(bus.f_stall), 0);
        bus.f_req = 1'b0;
        step();
        step();
        lookup_chk("full_a", 13'h0201, 1'b1, 13'h00A1);
        lookup_chk("full_b", 13'h0202, 1'b1, 13'h00A2);
        lookup_chk("full_c", 13'h0203, 1'b1, 13'h00A3);

        // Invalidate with a pending update and an in-flight lookup
        bus.u_wen  = 1'b1;
        bus.u_addr = 11'h300;
        bus.u_data = 16'h8333;
        bus.f_req  = 1'b1;
        bus.f_pc   = 13'h0123;
        step();
        bus.u_wen   = 1'b0;
        bus.inv_all = 1'b1;
        #1;
        check("inv_stall", 32'(bus.f_stall), 1);
        step();
        bus.inv_all = 1'b0;
        bus.f_req   = 1'b0;
        #1;
        check("inv_cancel", 32'(bus.f_vld), 0);
        check("inv_busy",   32'(bus.init_busy), 1);

        sweep("inv_sweep_part", 500);
        #1;
        check("inv_cnt500", 32'(bus.mem_addr), 500);
        rst_n = 1'b0;
        #1;
        check("mid_rst_wen", 32'(bus.mem_wen), 0);
        step();
        #1;
        check("mid_rst_cnt0", 32'(bus.mem_addr), 0);
        rst_n = 1'b1;
        sweep("rst_sweep", 2048);
        #1;
        check("rst_sweep_done", 32'(bus.init_busy), 0);
        lookup_chk("inv_old",  13'h0123, 1'b0, 13'h0000);
        lookup_chk("inv_pend", 13'h0300, 1'b0, 13'h0000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/bp_cache_ctrl.md
Name: bp_cache_ctrl

Overview:
Controller for the 2048-entry branch-prediction cache shared by the fetch stage (lookups) and the execute-stage PC calculator (updates).
- Owns the single-port cache RAM and clears it after reset or invalidate-all.
- Arbitrates one RAM access per cycle between fetch reads and buffered E-stage writes.
- Forwards buffered, not-yet-written updates to fetch lookups.

Parameters:
- IDX_W, 11, cache index width (entries = 2**IDX_W)
- PC_W, 13, word-PC width
- TAG_W, 2, tag width (PC_W-IDX_W)
- WBUF_DEPTH, 2, update write-buffer entries (power of 2, >=2)

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- f_req  in  1  fetch lookup request
- f_pc  in  PC_W  fetch word PC
- f_vld  out  1  lookup result valid (cycle after accepted f_req)
- f_hit  out  1  predicted-taken hit
- f_target  out  PC_W  predicted target
- f_stall  out  1  lookup not accepted this cycle
- u_wen  in  1  E-stage update strobe
- u_data  in  1+TAG_W+PC_W  {valid, pc tag, jump target}
- u_addr  in  IDX_W  update index (pc low bits)
- inv_all  in  1  invalidate whole cache (fence.i)
- init_busy  out  1  clearing in progress
- mem_addr  out  IDX_W  RAM address
- mem_wen  out  1  RAM write enable
- mem_wdata  out  1+TAG_W+PC_W  RAM write data
- mem_rdata  in  1+TAG_W+PC_W  RAM read data, valid one cycle after read address

Behaviour:
- Reset values: FSM=INIT, clear counter=0, buffer empty, f_vld=0, f_hit=0, f_target=0, init_busy=1, f_stall=1, mem_wen=0.
- INIT state:
  - Write mem_wdata=0 at mem_addr=counter every cycle; counter increments.
  - After index 2**IDX_W-1, go to RUN (2048 cycles).
  - f_stall=1 and init_busy=1 throughout; u_wen ignored.
- RUN state, priority per cycle:
  1. Buffer full: write buffer head to RAM, f_stall=1.
  2. Else f_req: read f_pc[IDX_W-1:0], f_stall=0.
  3. Else buffer non-empty: write head.
  4. Else idle.
- Lookup result, one cycle after acceptance (f_vld=1):
  - f_hit = rdata valid & rdata tag==f_pc tag (pc registered); f_target = rdata target.
  - Forwarding: if a buffer entry (newest wins) or a same-cycle RAM write matched the index at acceptance, its data replaces rdata.
- Update buffer:
  - u_wen with u_data valid bit set enqueues {u_addr,u_data}.
  - If u_addr matches an occupied entry, overwrite that entry in place (coalesce, no new slot).
  - Enqueue while full with no coalesce match: the same-cycle head write frees a slot; the RAM write and the enqueue occur together, so no update is ever dropped.
  - u_wen with valid bit 0: ignored.
- inv_all in RUN:
  - Discard buffer; cancel in-flight lookup (f_vld=0 next cycle).
  - Counter=0; enter INIT.
  - inv_all during INIT restarts the counter at 0.
- rst_n low in any state, including mid-INIT: all state returns to reset values next edge.
- Index/tag split: index=pc[IDX_W-1:0], tag=pc[PC_W-1:IDX_W]; counter wraps only on the INIT exit condition.

Optional Feature:
BP_STATS_EN
- Defined: adds outputs stat_lookups, stat_hits, stat_updates (32-bit each, reset 0, saturating at all-ones).
  - Increment respectively on f_vld, f_vld&f_hit, each accepted u_wen (coalesced updates count).
  - Cleared by inv_all.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Shared package: IDX_W/PC_W/TAG_W constants, entry field positions (valid bit, tag slice, target slice), FSM state encoding (INIT, RUN).
- One sub-module: bp_wbuf (coalescing write buffer with index-match forward port). FSM, arbitration and lookup pipeline live in bp_cache_ctrl.

Test Plan:
- Reset, hold rst_n=0 3 cycles then release:
  - init_busy=1 for exactly 2048 cycles; mem_wen=1 addresses 0..2047 data 0.
  - Then lookup f_pc=0x0123 -> f_vld=1, f_hit=0.
- Update u_addr=0x123, u_data={1,2'b00,13'h0456}, idle 2 cycles, lookup f_pc=0x0123 -> f_hit=1, f_target=0x0456. Lookup f_pc=0x0923 -> f_hit=0 (tag mismatch).
- Update then immediate lookup of same index with f_req held every cycle (write starved) -> lookup forwarded from buffer: f_hit=1, correct target.
- Coalescing: two updates to index 0x010 (targets 0x100, then 0x200) -> one buffer slot; later lookup returns 0x200.
- Buffer full: continuous f_req plus 3 distinct-index updates -> f_stall=1 on the drain cycle; all 3 entries later hit with correct targets.
- Invalidation: inv_all with 1 pending update -> init_busy=1 for 2048 cycles; afterwards the previously written index returns f_hit=0. Also assert rst_n=0 at INIT counter=500 -> INIT restarts from 0.
